// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter for a shared memory port
//
// Purpose: grants one of two requesters (0 = instruction fetch, 1 = data access)
// access to a single memory port, registers the winner's address, waits for
// mem_ack and pulses a per-requester done. Ties go to the requester not served last.
//
// Optional feature: define ARB_TIMEOUT_EN to add a BUSY-cycle counter that
// abandons an access after TIMEOUT cycles without mem_ack and pulses err.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst_n      - asynchronous active-low reset
//   req0/req1  - access requests
//   addr0/addr1- requester addresses (ADDR_WIDTH bits)
//   gnt0/gnt1  - high while that requester owns the port
//   done0/done1- one-cycle completion pulse
//   sel        - shared address/data mux select (0 = requester 0)
//   mem_req    - memory access strobe
//   mem_addr   - registered address of the granted requester
//   mem_ack    - memory completion, sampled on the rising edge
//   err        - one-cycle timeout pulse (ARB_TIMEOUT_EN builds only)

module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic                  sel,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                  err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    gnt0_q, gnt0_d;
  logic                    gnt1_q, gnt1_d;
  logic                    mem_req_q, mem_req_d;
  logic                    done0_q, done0_d;
  logic                    done1_q, done1_d;
  // Last-served pointer: 1 after reset so requester 0 wins the first tie.
  logic                    last_q, last_d;

  logic                    any_req;
  logic                    winner;
  logic                    timeout_hit;

  assign any_req = req0 | req1;
  // On a tie pick the requester not served last; otherwise the sole requester.
  assign winner  = (req0 & req1) ? ~last_q : req1;

  // Out-of-range TIMEOUT (outside 1..255) elaborates this marker block so it
  // shows up in the elaborated hierarchy.
  if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_timeout_out_of_range
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // cnt_q holds the number of completed BUSY cycles; the edge that would
  // complete the TIMEOUT-th cycle without an ack ends the access.
  assign timeout_hit = (state_q == BUSY) && !mem_ack && (cnt_q == TO_LAST);
  assign err         = err_q;
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (mem_ack || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    sel_d      = sel_q;
    mem_addr_d = mem_addr_q;
    gnt0_d     = gnt0_q;
    gnt1_d     = gnt1_q;
    mem_req_d  = mem_req_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    last_d     = last_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d      = winner;
          mem_addr_d = winner ? addr1 : addr0;
          gnt0_d     = ~winner;
          gnt1_d     = winner;
          mem_req_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d      = 8'd0;
`endif
        end
      end
      BUSY: begin
        // An ack on the same edge as the timeout wins: the access completed.
        if (mem_ack) begin
          gnt0_d    = 1'b0;
          gnt1_d    = 1'b0;
          mem_req_d = 1'b0;
          done0_d   = ~sel_q;
          done1_d   = sel_q;
          last_d    = sel_q;
        end else if (timeout_hit) begin
          gnt0_d    = 1'b0;
          gnt1_d    = 1'b0;
          mem_req_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
          err_d     = 1'b1;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d     = cnt_q + 8'd1;
`endif
        end
      end
      DONE: begin
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        mem_req_d = 1'b0;
      end
      default: begin
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= 1'b0;
      mem_addr_q <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      sel_q      <= sel_d;
      mem_addr_q <= mem_addr_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      mem_req_q  <= mem_req_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      last_q     <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  assign sel      = sel_q;
  assign mem_addr = mem_addr_q;
  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign mem_req  = mem_req_q;
  assign done0    = done0_q;
  assign done1    = done1_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, giving the width of every address bus.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, giving the maximum wait for mem_ack in cycles (range 1-255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have ports req0 and req1, input, 1 bit each: access requests from requester 0 (instruction fetch) and requester 1 (data access).
REQ-006 The block SHALL have ports addr0 and addr1, input, ADDR_WIDTH bits each: the requester addresses.
REQ-007 The block SHALL have ports gnt0 and gnt1, output, 1 bit each: high while that requester owns the port.
REQ-008 The block SHALL have ports done0 and done1, output, 1 bit each: a one-cycle completion pulse.
REQ-009 The block SHALL have port sel, output, 1 bit: the select for the shared 2-input address/data mux (0 = requester 0, 1 = requester 1).
REQ-010 The block SHALL have port mem_req, output, 1 bit: memory access strobe.
REQ-011 The block SHALL have port mem_addr, output, ADDR_WIDTH bits: the registered address of the granted requester.
REQ-012 The block SHALL have port mem_ack, input, 1 bit: memory completion, sampled on the rising edge of clk.
REQ-013 The block SHALL have port err, output, 1 bit: a one-cycle timeout pulse; it exists only when ARB_TIMEOUT_EN is defined.

Function
REQ-014 The block SHALL implement a state machine with states IDLE, BUSY and DONE.
REQ-015 In IDLE with any req high, on the next edge the block SHALL:
- pick a winner;
- register sel and mem_addr;
- assert gnt of the winner and mem_req;
- enter BUSY.
REQ-016 When only one request is high, the block SHALL grant that requester.
REQ-017 When req0 and req1 are both high, the block SHALL grant the requester not served last (round-robin); the last-served pointer resets to 1, so requester 0 wins first.
REQ-018 In BUSY, the block SHALL hold sel, mem_addr, gnt and mem_req stable until mem_ack is sampled high.
REQ-019 On mem_ack in BUSY, the block SHALL:
- on that edge, enter DONE and update the last-served pointer;
- drop mem_req and gnt;
- pulse the winner's done for exactly the DONE cycle.
REQ-020 From DONE, the block SHALL always return to IDLE. Grant latency is 1 cycle from req in IDLE, and back-to-back grants are separated by at least 2 cycles.
REQ-021 If a requester deasserts req during BUSY, the access SHALL still complete, with done pulsed normally.
REQ-022 The block SHALL ignore mem_ack in IDLE and DONE.
REQ-023 The block SHALL hold at most one gnt high at any time, and gnt0 and gnt1 SHALL never both be high.
REQ-024 sel SHALL retain its last value outside BUSY.
REQ-025 mem_addr SHALL change only on a grant.

Reset
REQ-026 rst_n low SHALL immediately force the following, regardless of clk:
- state IDLE, with pending transactions abandoned and no done pulse;
- gnt0, gnt1, done0, done1, mem_req, err = 0;
- sel = 0, mem_addr = 0, last-served pointer = 1, timeout counter = 0.
REQ-027 After rst_n rises, the first arbitration SHALL occur on the first clk edge with req high.

Configuration
REQ-028 With macro ARB_TIMEOUT_EN defined, the block SHALL:
- count BUSY cycles;
- if mem_ack has not arrived after TIMEOUT cycles in BUSY, drop mem_req and gnt, pulse err for one cycle (no done), and enter DONE;
- not update the last-served pointer on timeout.
REQ-029 Without ARB_TIMEOUT_EN, the block SHALL have no err port and no counter, and SHALL wait in BUSY indefinitely.

Verification
REQ-030 Single request: req0=1, addr0=0x3C, mem_ack 3 cycles later -> gnt0 and mem_req next edge, mem_addr=0x3C, sel=0, done0 one-cycle pulse, back to IDLE.
REQ-031 Contention: req0=req1=1 held, mem_ack 1 cycle after each mem_req -> grant order 0,1,0,1, done pulses alternating, gnt never both high.
REQ-032 Request drop: req1=1 for 1 cycle only, addr1=0xA5 -> access completes with mem_addr=0xA5, sel=1, done1 pulsed.
REQ-033 Reset mid-BUSY: assert rst_n=0 between edges during BUSY -> mem_req, gnt and sel drop to 0 at once; no done; next req0 granted normally.
REQ-034 Timeout (ARB_TIMEOUT_EN, TIMEOUT=4): req0, never ack -> mem_req high 4 cycles, then err pulse, no done0; next contention grants requester 0 first.
REQ-035 Stray ack: mem_ack=1 in IDLE with no requests -> no state change, all outputs stay 0.
